mem_align_trap_unit: RTL and testbench
======================================

Name: mem_align_trap_unit

Overview:
- Parametrised successor to the single-width load/store misalignment detector.
- Checks each load/store issued by the memory stage against its access size (byte/half/word/double), classifies load vs store cause, and captures mcause/mepc/mtval.
- Drives a multi-cycle flush and holds the trap until the trap/CSR logic acknowledges redirection.
- Sits between the memory-stage issue logic and the CSR/trap-redirect block.

Parameters:
- XLEN, 32: address/PC/CSR width; legal values 32 or 64.
- FLUSH_CYCLES, 2: number of cycles flush is held high per trap; minimum 1.
- LOAD_CAUSE, 4: mcause value for a misaligned load.
- STORE_CAUSE, 6: mcause value for a misaligned store.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  memory request present this cycle
- req_ready  out  1  unit accepts/checks requests (high only in IDLE)
- req_opcode  in  7  instruction opcode (load 7'b0000011, store 7'b0100011)
- req_funct3  in  3  access size/sign field
- req_addr  in  XLEN  effective address
- req_pc  in  XLEN  PC of the memory instruction
- trap_ack  in  1  trap logic has taken the redirect
- exception  out  1  one-cycle pulse on trap detection
- flush  out  1  pipeline flush, held FLUSH_CYCLES cycles
- busy  out  1  trap pending (FLUSH or WAIT_ACK)
- mcause  out  XLEN  captured cause
- mepc  out  XLEN  captured PC
- mtval  out  XLEN  captured faulting address

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset.
- Reset values:
  - state = IDLE.
  - exception, flush, busy = 0.
  - req_ready = 1.
  - mcause, mepc, mtval = 0.
- Reset asserted mid-trap returns to IDLE in the next cycle. It overrides trap_ack and req_valid.
- Check fires when req_valid & req_ready & opcode ∈ {load, store}. Other opcodes never trap.
- Misalignment by funct3:
  - 000/100 (byte): never misaligned.
  - 001/101 (half): addr[0] != 0.
  - 010 (word), and 110 (load only, XLEN=64): addr[1:0] != 0.
  - 011 (double, XLEN=64 only): addr[2:0] != 0.
  - Any other funct3, or 011/110 with XLEN=32: not checked, no trap.
  - Store funct3 values 100/101/110 are not checked.
- FSM:
  - IDLE: a detected misalignment moves to FLUSH on the next edge. The same edge captures:
    - mcause = LOAD_CAUSE or STORE_CAUSE, zero-extended to XLEN.
    - mepc = req_pc.
    - mtval = req_addr.
  - Also on that edge: exception=1 for exactly one cycle, flush=1, and the flush counter is loaded with FLUSH_CYCLES-1.
  - FLUSH: flush=1 and busy=1. The counter decrements each cycle. At 0, move to WAIT_ACK. trap_ack is ignored in FLUSH.
  - WAIT_ACK: flush=0 and busy=1. trap_ack=1 moves to IDLE on the next edge.
- Latency: request cycle N → exception/flush/busy high in cycle N+1. flush is high in cycles N+1 .. N+FLUSH_CYCLES.
- req_ready = (state == IDLE), combinational from state.
- Requests arriving while not ready are dropped, not queued. The pipeline is being flushed.
- When trap_ack and req_valid arrive together in WAIT_ACK, the request is ignored and the unit returns to IDLE.
- mcause/mepc/mtval hold their value until the next trap or reset. They are not cleared by trap_ack.
- Aligned accesses change no outputs.

Optional Feature:
- Macro MISALIGN_PERF_CNT_EN.
- Defined:
  - Adds output trap_count [31:0], reset to 0.
  - Increments by 1 on every exception pulse and saturates at 32'hFFFFFFFF.
  - Adds output last_was_store [1], set at capture time and reset to 0.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Reset, then lw (opcode 0000011, funct3 010) at 0x1000_0002, pc 0x400, XLEN=32, FLUSH_CYCLES=2 → next cycle: exception pulse; flush high for 2 cycles; mcause=4, mepc=0x400, mtval=0x1000_0002; busy held; trap_ack → IDLE, req_ready=1.
- sh (0100011/001) at 0x3 → mcause=6, mtval=0x3. sh at 0x2 → no trap. sb at 0x7 → no trap. lhu (101) at 0x5 → mcause=4.
- Second misaligned lw while in FLUSH or WAIT_ACK → ignored; mtval keeps the first address.
- trap_ack pulsed during FLUSH → still reaches WAIT_ACK. trap_ack together with a misaligned req in WAIT_ACK → IDLE, no new exception.
- XLEN=64: ld (011) at 0x...04 → trap, mcause=4. Same ld with XLEN=32 → no trap. Non-memory opcode 0110011 at 0x1 → no trap.
- reset asserted in FLUSH → next cycle flush=0, busy=0, all CSR outputs 0. With MISALIGN_PERF_CNT_EN: 3 traps → trap_count=3, then reset → 0.

Source files
------------

// File: rtl/mem_align_trap_unit.sv
// mem_align_trap_unit: load/store misalignment detector with trap capture.
// Checks each memory-stage request against its access size and captures
// mcause/mepc/mtval on a misaligned access. It then holds flush for
// FLUSH_CYCLES cycles and waits for trap_ack before it accepts requests again.
// Optional feature (macro MISALIGN_PERF_CNT_EN): saturating trap_count
// output plus a last_was_store flag.

module mem_align_trap_unit #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int LOAD_CAUSE   = 4,
  parameter int STORE_CAUSE  = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [6:0]      req_opcode,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_pc,
  input  logic            trap_ack,
  output logic            exception,
  output logic            flush,
  output logic            busy,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mtval
`ifdef MISALIGN_PERF_CNT_EN
  ,
  output logic [31:0]     trap_count,
  output logic            last_was_store
`endif
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam int         CW       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam bit         IS_RV64  = (XLEN == 64);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          is_load, is_store, misaligned, trap_det;

  // Decode the access size and flag a misaligned load/store offered while ready
  always_comb begin
    is_load    = (req_opcode == OP_LOAD);
    is_store   = (req_opcode == OP_STORE);
    misaligned = 1'b0;
    case (req_funct3)
      3'b001:  misaligned = req_addr[0];
      // Unsigned half exists only for loads; store encodings 100/101/110 are unchecked
      3'b101:  misaligned = is_load & req_addr[0];
      3'b010:  misaligned = |req_addr[1:0];
      // lwu only exists on RV64
      3'b110:  misaligned = IS_RV64 & is_load & (|req_addr[1:0]);
      // ld/sd only exist on RV64
      3'b011:  misaligned = IS_RV64 & (|req_addr[2:0]);
      default: misaligned = 1'b0;
    endcase
    trap_det = req_valid & req_ready & (is_load | is_store) & misaligned;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; trap_ack is only honoured in WAIT_ACK
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (trap_det)     state_nxt = FLUSH;
      FLUSH:    if (cnt == '0)    state_nxt = WAIT_ACK;
      WAIT_ACK: if (trap_ack)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    req_ready = (state == IDLE);
    flush     = (state == FLUSH);
    busy      = (state != IDLE);
  end

  // Flush length counter, loaded on the capture edge and counted down in FLUSH
  always_ff @(posedge clk) begin
    if (reset)                          cnt <= '0;
    else if (trap_det)                  cnt <= CW'(FLUSH_CYCLES - 1);
    else if (state == FLUSH && cnt != '0) cnt <= cnt - 1'b1;
  end

  // Trap capture: CSR values persist until the next trap or reset
  always_ff @(posedge clk) begin
    if (reset) begin
      exception <= 1'b0;
      mcause    <= '0;
      mepc      <= '0;
      mtval     <= '0;
    end else begin
      exception <= trap_det;
      if (trap_det) begin
        mcause <= is_store ? XLEN'(STORE_CAUSE) : XLEN'(LOAD_CAUSE);
        mepc   <= req_pc;
        mtval  <= req_addr;
      end
    end
  end

`ifdef MISALIGN_PERF_CNT_EN
  // Saturating trap counter; counted on the capture edge so it moves with the pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      trap_count     <= '0;
      last_was_store <= 1'b0;
    end else if (trap_det) begin
      if (trap_count != 32'hFFFF_FFFF) trap_count <= trap_count + 32'd1;
      last_was_store <= is_store;
    end
  end
`endif

endmodule

// File: tb/tb_mem_align_trap_unit.sv
// Directed bench for mem_align_trap_unit: one XLEN=32/FLUSH_CYCLES=2 instance
// and one XLEN=64/FLUSH_CYCLES=1 instance.
module tb_mem_align_trap_unit;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] OP = 7'b0110011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // XLEN=32 instance
  logic        a_reset, a_valid, a_ready, a_ack, a_exc, a_flush, a_busy;
  logic [6:0]  a_op;
  logic [2:0]  a_f3;
  logic [31:0] a_addr, a_pc, a_mcause, a_mepc, a_mtval;
`ifdef MISALIGN_PERF_CNT_EN
  logic [31:0] a_cnt;
  logic        a_lws;
`endif

  // XLEN=64 instance
  logic        b_reset, b_valid, b_ready, b_ack, b_exc, b_flush, b_busy;
  logic [6:0]  b_op;
  logic [2:0]  b_f3;
  logic [63:0] b_addr, b_pc, b_mcause, b_mepc, b_mtval;
`ifdef MISALIGN_PERF_CNT_EN
  logic [31:0] b_cnt;
  logic        b_lws;
`endif

  mem_align_trap_unit #(.XLEN(32), .FLUSH_CYCLES(2)) dut32 (
    .clk(clk), .reset(a_reset), .req_valid(a_valid), .req_ready(a_ready),
    .req_opcode(a_op), .req_funct3(a_f3), .req_addr(a_addr), .req_pc(a_pc),
    .trap_ack(a_ack), .exception(a_exc), .flush(a_flush), .busy(a_busy),
    .mcause(a_mcause), .mepc(a_mepc), .mtval(a_mtval)
`ifdef MISALIGN_PERF_CNT_EN
    , .trap_count(a_cnt), .last_was_store(a_lws)
`endif
  );

  mem_align_trap_unit #(.XLEN(64), .FLUSH_CYCLES(1)) dut64 (
    .clk(clk), .reset(b_reset), .req_valid(b_valid), .req_ready(b_ready),
    .req_opcode(b_op), .req_funct3(b_f3), .req_addr(b_addr), .req_pc(b_pc),
    .trap_ack(b_ack), .exception(b_exc), .flush(b_flush), .busy(b_busy),
    .mcause(b_mcause), .mepc(b_mepc), .mtval(b_mtval)
`ifdef MISALIGN_PERF_CNT_EN
    , .trap_count(b_cnt), .last_was_store(b_lws)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and checks happen 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_req(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] pc);
    a_valid = 1'b1; a_op = op; a_f3 = f3; a_addr = addr; a_pc = pc;
  endtask

  // Called in the first trap cycle: ack held high, returns in IDLE
  task automatic a_drain(input string tag);
    a_valid = 1'b0; a_ack = 1'b1;
    tick(); tick(); tick();
    chk({tag, "_ready_after_ack"}, {63'd0, a_ready}, 64'd1);
    a_ack = 1'b0;
  endtask

  initial begin
    a_reset = 1'b1; a_valid = 1'b0; a_ack = 1'b0; a_op = '0; a_f3 = '0; a_addr = '0; a_pc = '0;
    b_reset = 1'b1; b_valid = 1'b0; b_ack = 1'b0; b_op = '0; b_f3 = '0; b_addr = '0; b_pc = '0;
    tick(); tick();
    a_reset = 1'b0; b_reset = 1'b0;

    // Reset state
    chk("rst_ready",  {63'd0, a_ready}, 64'd1);
    chk("rst_exc",    {63'd0, a_exc},   64'd0);
    chk("rst_flush",  {63'd0, a_flush}, 64'd0);
    chk("rst_busy",   {63'd0, a_busy},  64'd0);
    chk("rst_mcause", {32'd0, a_mcause}, 64'd0);
    chk("rst_mepc",   {32'd0, a_mepc},   64'd0);
    chk("rst_mtval",  {32'd0, a_mtval},  64'd0);
`ifdef MISALIGN_PERF_CNT_EN
    chk("rst_cnt",    {32'd0, a_cnt},    64'd0);
`endif

    // lw at 0x1000_0002: trap, flush 2 cycles, then wait for ack
    a_req(LD, 3'b010, 32'h1000_0002, 32'h400);
    tick();
    chk("lw_exc",    {63'd0, a_exc},   64'd1);
    chk("lw_flush1", {63'd0, a_flush}, 64'd1);
    chk("lw_busy",   {63'd0, a_busy},  64'd1);
    chk("lw_ready",  {63'd0, a_ready}, 64'd0);
    chk("lw_mcause", {32'd0, a_mcause}, 64'd4);
    chk("lw_mepc",   {32'd0, a_mepc},   64'h400);
    chk("lw_mtval",  {32'd0, a_mtval},  64'h1000_0002);
    // Second misaligned lw plus trap_ack during FLUSH: both ignored
    a_req(LD, 3'b010, 32'h5, 32'h404);
    a_ack = 1'b1;
    tick();
    chk("lw_exc_once", {63'd0, a_exc},   64'd0);
    chk("lw_flush2",   {63'd0, a_flush}, 64'd1);
    a_valid = 1'b0; a_ack = 1'b0;
    tick();
    chk("wait_flush",  {63'd0, a_flush}, 64'd0);
    chk("wait_busy",   {63'd0, a_busy},  64'd1);
    chk("wait_mtval",  {32'd0, a_mtval}, 64'h1000_0002);
    tick();
    chk("wait_hold",   {63'd0, a_busy},  64'd1);
    // Ack together with a misaligned sh: back to IDLE, no new trap
    a_req(ST, 3'b001, 32'h3, 32'h408);
    a_ack = 1'b1;
    tick();
    chk("ack_ready",   {63'd0, a_ready}, 64'd1);
    chk("ack_busy",    {63'd0, a_busy},  64'd0);
    chk("ack_exc",     {63'd0, a_exc},   64'd0);
    chk("ack_mtval",   {32'd0, a_mtval}, 64'h1000_0002);
    chk("ack_mcause",  {32'd0, a_mcause}, 64'd4);
    a_valid = 1'b0; a_ack = 1'b0;
    tick();
    chk("ack_no_trap", {63'd0, a_exc},   64'd0);

    // sh at 0x3 -> store cause
    a_req(ST, 3'b001, 32'h3, 32'h500);
    tick();
    chk("sh_exc",    {63'd0, a_exc},   64'd1);
    chk("sh_mcause", {32'd0, a_mcause}, 64'd6);
    chk("sh_mtval",  {32'd0, a_mtval},  64'h3);
    chk("sh_mepc",   {32'd0, a_mepc},   64'h500);
`ifdef MISALIGN_PERF_CNT_EN
    chk("sh_lws",    {63'd0, a_lws},   64'd1);
`endif
    a_drain("sh");

    // Aligned / unchecked accesses: no trap, CSRs untouched
    a_req(ST, 3'b001, 32'h2, 32'h510);
    tick();
    chk("sh2_exc",  {63'd0, a_exc},  64'd0);
    chk("sh2_busy", {63'd0, a_busy}, 64'd0);
    a_req(ST, 3'b000, 32'h7, 32'h514);
    tick();
    chk("sb7_exc",  {63'd0, a_exc},  64'd0);
    a_req(OP, 3'b001, 32'h1, 32'h518);
    tick();
    chk("alu_exc",  {63'd0, a_exc},  64'd0);
    a_req(ST, 3'b101, 32'h1, 32'h51c);
    tick();
    chk("st101_exc", {63'd0, a_exc}, 64'd0);
    a_req(LD, 3'b011, 32'h4, 32'h520);
    tick();
    chk("ld32_exc", {63'd0, a_exc},  64'd0);
    chk("keep_mtval", {32'd0, a_mtval}, 64'h3);

    // lhu at 0x5 -> load cause
    a_req(LD, 3'b101, 32'h5, 32'h600);
    tick();
    chk("lhu_exc",    {63'd0, a_exc},   64'd1);
    chk("lhu_mcause", {32'd0, a_mcause}, 64'd4);
    chk("lhu_mtval",  {32'd0, a_mtval},  64'h5);
`ifdef MISALIGN_PERF_CNT_EN
    chk("lhu_lws",    {63'd0, a_lws},   64'd0);
`endif
    a_drain("lhu");
`ifdef MISALIGN_PERF_CNT_EN
    chk("cnt3", {32'd0, a_cnt}, 64'd3);
`endif

    // Reset in FLUSH clears everything next cycle
    a_req(ST, 3'b010, 32'h6, 32'h700);
    tick();
    chk("sw_flush", {63'd0, a_flush}, 64'd1);
    a_valid = 1'b0; a_reset = 1'b1; a_ack = 1'b1;
    tick();
    a_reset = 1'b0; a_ack = 1'b0;
    chk("rf_flush",  {63'd0, a_flush}, 64'd0);
    chk("rf_busy",   {63'd0, a_busy},  64'd0);
    chk("rf_exc",    {63'd0, a_exc},   64'd0);
    chk("rf_ready",  {63'd0, a_ready}, 64'd1);
    chk("rf_mcause", {32'd0, a_mcause}, 64'd0);
    chk("rf_mepc",   {32'd0, a_mepc},   64'd0);
    chk("rf_mtval",  {32'd0, a_mtval},  64'd0);
`ifdef MISALIGN_PERF_CNT_EN
    chk("rf_cnt",    {32'd0, a_cnt},    64'd0);
`endif

    // XLEN=64, FLUSH_CYCLES=1: ld at ...04 traps, flush for one cycle only
    b_valid = 1'b1; b_op = LD; b_f3 = 3'b011;
    b_addr = 64'h8000_0000_0000_0004; b_pc = 64'h1_0000_0000;
    tick();
    b_valid = 1'b0;
    chk("ld64_exc",    {63'd0, b_exc},   64'd1);
    chk("ld64_flush",  {63'd0, b_flush}, 64'd1);
    chk("ld64_mcause", b_mcause, 64'd4);
    chk("ld64_mepc",   b_mepc,   64'h1_0000_0000);
    chk("ld64_mtval",  b_mtval,  64'h8000_0000_0000_0004);
    tick();
    chk("ld64_flush_end", {63'd0, b_flush}, 64'd0);
    chk("ld64_busy",      {63'd0, b_busy},  64'd1);
    b_ack = 1'b1;
    tick();
    b_ack = 1'b0;
    chk("ld64_ready", {63'd0, b_ready}, 64'd1);
    // Aligned sd: no trap
    b_valid = 1'b1; b_op = ST; b_f3 = 3'b011; b_addr = 64'h8;
    tick();
    chk("sd64_exc", {63'd0, b_exc}, 64'd0);
    // lwu at 0x2 traps on RV64
    b_op = LD; b_f3 = 3'b110; b_addr = 64'h2; b_pc = 64'h20;
    tick();
    b_valid = 1'b0;
    chk("lwu64_exc",   {63'd0, b_exc}, 64'd1);
    chk("lwu64_mtval", b_mtval, 64'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
